// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, inactive output code and the one-hot decode function.
package decoder_pkg;
   localparam int SEL_W = 2;
   localparam int N_OUT = 4;
   localparam logic [N_OUT-1:0] D_OFF = '0;
   function automatic logic [N_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel, input logic en);
      logic [N_OUT-1:0] one;
      one = 4'b0001;
      return en ? one << sel : D_OFF;
   endfunction
endpackage

// File: rtl/decoder_2to4_core.sv
// decoder_2to4_core: combinational 2-to-4 decode with optional output inversion.
//   a, b : select MSB/LSB
//   en   : active-high enable
//   d    : {d3,d2,d1,d0} decode, inverted when OUT_ACTIVE_LOW
module decoder_2to4_core
   import decoder_pkg::*;
#(
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic             a,
   input  logic             b,
   input  logic             en,
   output logic [N_OUT-1:0] d
);
   assign d = onehot4({a, b}, en) ^ {N_OUT{OUT_ACTIVE_LOW}};
endmodule

// File: rtl/decoder_2to4.sv
// decoder_2to4: 2-to-4 select decoder with optional registered outputs.
//   clk   : rising-edge clock (unused when REGISTERED=0)
//   rst_n : synchronous active-low reset (unused when REGISTERED=0)
//   a, b  : select {a,b}, a is MSB
//   en    : active-high enable
//   d3-d0 : decode outputs
module decoder_2to4
   import decoder_pkg::*;
#(
   parameter bit REGISTERED     = 1'b1,
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic en,
   output logic d3,
   output logic d2,
   output logic d1,
   output logic d0
);
   localparam logic [N_OUT-1:0] INACTIVE = D_OFF ^ {N_OUT{OUT_ACTIVE_LOW}};
   logic [N_OUT-1:0] dec;
   logic [N_OUT-1:0] q;
   decoder_2to4_core #(.OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)) u_core (
      .a (a),
      .b (b),
      .en(en),
      .d (dec)
   );
   if (REGISTERED) begin : g_reg
      // The whole code is captured in one register so a, b and en changes land together.
      always_ff @(posedge clk)
         q <= !rst_n ? INACTIVE : dec;
   end else begin : g_comb
      assign q = dec;
   end
   assign {d3, d2, d1, d0} = q;
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: directed self-checking bench for decoder_2to4 and its parameter variants.
module tb_decoder_2to4;
   logic clk = 1'b0;
   logic rst_n, a, b, en;
   logic r3, r2, r1, r0;
   logic c3, c2, c1, c0;
   logic l3, l2, l1, l0;
   int   passed = 0;
   int   total  = 0;
   logic [3:0] exp_on [4];

   always #5 clk = ~clk;

   decoder_2to4 u_reg (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
      .d3(r3), .d2(r2), .d1(r1), .d0(r0)
   );
   decoder_2to4 #(.REGISTERED(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
      .d3(c3), .d2(c2), .d1(c1), .d0(c0)
   );
   decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1)) u_low (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
      .d3(l3), .d2(l2), .d1(l1), .d0(l0)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_on = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1;
      step();
      chk("reset_c1", {r3, r2, r1, r0}, 4'b0000);
      chk("reset_low_c1", {l3, l2, l1, l0}, 4'b1111);
      step();
      chk("reset_c2", {r3, r2, r1, r0}, 4'b0000);
      chk("comb_in_reset", {c3, c2, c1, c0}, 4'b1000);
      rst_n = 1'b1;
      step();
      chk("reset_release", {r3, r2, r1, r0}, 4'b1000);
      chk("reset_release_low", {l3, l2, l1, l0}, 4'b0111);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         {a, b} = 2'(i);
         step();
         chk($sformatf("disabled_%0d", i), {r3, r2, r1, r0}, 4'b0000);
         chk($sformatf("disabled_low_%0d", i), {l3, l2, l1, l0}, 4'b1111);
      end
      for (int i = 0; i < 4; i++) begin
         en = 1'b1;
         {a, b} = 2'(i);
         #1;
         chk($sformatf("comb_%0d", i), {c3, c2, c1, c0}, exp_on[i]);
         if (i == 0)
            chk("latency_hold", {r3, r2, r1, r0}, 4'b0000);
         step();
         chk($sformatf("enabled_%0d", i), {r3, r2, r1, r0}, exp_on[i]);
      end
      en = 1'b0;
      #1;
      chk("drop_before_edge", {r3, r2, r1, r0}, 4'b1000);
      chk("comb_drop", {c3, c2, c1, c0}, 4'b0000);
      step();
      chk("enable_drop", {r3, r2, r1, r0}, 4'b0000);
      a = 1'b0; b = 1'b0;
      step();
      a = 1'b1; b = 1'b1; en = 1'b1;
      step();
      chk("simultaneous", {r3, r2, r1, r0}, 4'b1000);
      a = 1'b1; b = 1'b0;
      step();
      chk("mid_pre", {r3, r2, r1, r0}, 4'b0100);
      rst_n = 1'b0;
      step();
      chk("mid_reset", {r3, r2, r1, r0}, 4'b0000);
      chk("mid_reset_low", {l3, l2, l1, l0}, 4'b1111);
      rst_n = 1'b1;
      step();
      chk("mid_release", {r3, r2, r1, r0}, 4'b0100);
      chk("low_sel10", {l3, l2, l1, l0}, 4'b1011);
      a = 1'b0; b = 1'b1;
      #1;
      chk("comb_sel01", {c3, c2, c1, c0}, 4'b0010);
      en = 1'b0;
      step();
      chk("low_disabled", {l3, l2, l1, l0}, 4'b1111);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
- 2-to-4 line decoder with active-high enable.
- Outputs are one-hot when enabled and all-zero when disabled.
- Used as a select/address decoder in the datapath.
- Outputs are registered by default so downstream logic sees glitch-free selects; an optional combinational mode exists for timing-critical paths.

Parameters:
- REGISTERED, 1: 1 = outputs registered (1-cycle latency); 0 = purely combinational outputs (clk/rst_n unused).
- OUT_ACTIVE_LOW, 0: 1 = inverts all four decode outputs (D bits) at the port; the disabled state then reads 1111.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- a  input  1  select MSB.
- b  input  1  select LSB.
- en  input  1  enable, active-high.
- d3  output  1  asserted when en=1, {a,b}=11.
- d2  output  1  asserted when en=1, {a,b}=10.
- d1  output  1  asserted when en=1, {a,b}=01.
- d0  output  1  asserted when en=1, {a,b}=00.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Select index sel = {a,b}; a is the MSB.
- Decode (OUT_ACTIVE_LOW=0): d[i] = en & (sel == i). Exactly one output high when en=1; all low when en=0.
- {d3,d2,d1,d0} values:
  - en=0 -> 0000.
  - sel=00 -> 0001.
  - sel=01 -> 0010.
  - sel=10 -> 0100.
  - sel=11 -> 1000.
- REGISTERED=1:
  - Inputs sampled on the rising clk edge; outputs update on that edge (1-cycle latency).
  - No combinational path from inputs to outputs.
- REGISTERED=0: outputs follow inputs combinationally with zero latency.
- Reset (REGISTERED=1):
  - rst_n low at a rising edge forces all outputs inactive (0000, or 1111 if OUT_ACTIVE_LOW).
  - Reset has priority over en/a/b.
  - Reset asserted mid-operation clears outputs at the next edge.
  - First decode after release appears one edge after rst_n is sampled high.
- Enable drop: en 1->0 clears all outputs at the next edge, regardless of a/b.
- Simultaneous change of a, b and en in one cycle: the output reflects the new sampled values together; no intermediate code is ever visible.
- X/Z on inputs is not supported; the bench drives defined values at all times after reset.
- No state machine; no handshake.

Decomposition:
- Shared package decoder_pkg holds:
  - localparam SEL_W = 2 and N_OUT = 4.
  - The inactive-output constant.
  - A function onehot4(sel, en) returning the 4-bit decode.
- Sub-module decoder_2to4_core (pure combinational decode + optional inversion).
- Top decoder_2to4 adds the optional output register stage and reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, a=1, b=1 -> outputs 0000 during reset; 1000 one edge after rst_n=1.
- Disabled: en=0, sweep a,b through 00,01,10,11 -> outputs remain 0000 every cycle.
- Enabled sweep: en=1, {a,b}=00,01,10,11 on successive cycles -> 0001, 0010, 0100, 1000, each one cycle after the input change.
- Enable drop: en=1, {a,b}=11 holding 1000; set en=0 -> 0000 at the next edge.
- Mid-operation reset: en=1, {a,b}=10 with outputs 0100; pulse rst_n low for one cycle -> 0000 at that edge; 0100 again one edge after release.
- Parameter variants:
  - REGISTERED=0: {a,b}=01, en=1 -> 0010 with no clock edge.
  - OUT_ACTIVE_LOW=1: en=0 -> 1111; {a,b}=10, en=1 -> 1011.
